// File: rtl/div_pkg.sv
// Shared constants and packed request/result records for the divider issue queue.
// Build option: DIV_TAG_EN adds the tag field to both records; without it there is no tag storage.
// The records are sized by DIV_WL/DIV_TW, so the top's WL/TW parameters must keep these values.
package div_pkg;

  localparam int DIV_WL = 16;
  localparam int DIV_TW = 4;

`ifdef DIV_TAG_EN
  typedef struct packed {
    logic [2*DIV_WL-1:0] op1;
    logic [DIV_WL-1:0]   op2;
    logic                unsigned_;
    logic [DIV_TW-1:0]   tag;
  } div_req_t;

  typedef struct packed {
    logic [DIV_WL-1:0] quot;
    logic [DIV_WL-1:0] rem;
    logic [DIV_TW-1:0] tag;
  } div_rsp_t;
`else
  typedef struct packed {
    logic [2*DIV_WL-1:0] op1;
    logic [DIV_WL-1:0]   op2;
    logic                unsigned_;
  } div_req_t;

  typedef struct packed {
    logic [DIV_WL-1:0] quot;
    logic [DIV_WL-1:0] rem;
  } div_rsp_t;
`endif

endpackage

// File: rtl/div_sfifo.sv
// Purpose: generic synchronous FIFO, WIDTH bits x DEPTH entries.
// Latency: data pushed on an edge is visible on dout after that edge; no fall-through.
// Backpressure: push ignored when full, pop ignored when empty; dout reads 0 while empty.
// Ports: clk, rst_n (async active-low), push/din, pop/dout, full, empty.
module div_sfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Gating keeps the output at a defined zero out of reset without resetting the array.
  assign dout    = empty ? '0 : mem[rd_ptr];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/div_issue_queue.sv
// Purpose: feeds one request per 16-iteration window to a free-running divider and queues its results.
// Latency: issue edge (div_iter==15) to capture edge is 17 edges; rsp_valid follows; 18..33 cycles request to result.
// Backpressure: req_ready drops when the request FIFO is full; issue waits on result credits, so results are never dropped.
// Ports: req_* valid/ready request in; div_* operands out / iteration+results in; rsp_* valid/ready result out.
// Build option: DIV_TAG_EN carries req_tag through to rsp_tag; otherwise rsp_tag is 0 and req_tag is ignored.
module div_issue_queue
  import div_pkg::*;
#(
  parameter int WL     = DIV_WL,
  parameter int QDEPTH = 4,
  parameter int RDEPTH = 2,
  parameter int TW     = DIV_TW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2*WL-1:0] req_op1,
  input  logic [WL-1:0]   req_op2,
  input  logic            req_unsigned,
  input  logic [TW-1:0]   req_tag,
  output logic [2*WL-1:0] div_op1,
  output logic [WL-1:0]   div_op2,
  output logic            div_unsigned,
  input  logic [3:0]      div_iter,
  input  logic [WL-1:0]   div_quot,
  input  logic [WL-1:0]   div_rem,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [WL-1:0]   rsp_quot,
  output logic [WL-1:0]   rsp_rem,
  output logic [TW-1:0]   rsp_tag
);

  localparam int            CW         = $clog2(RDEPTH + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(RDEPTH);

  div_req_t      req_in;
  div_req_t      req_head;
  div_req_t      issue_src;
  div_req_t      issue_q;
  div_rsp_t      rsp_in;
  div_rsp_t      rsp_head;

  logic          req_full;
  logic          req_empty;
  logic          req_fire;
  logic          req_push;
  logic          req_pop;
  logic          rsp_full;
  logic          rsp_empty;
  logic          rsp_push;
  logic          rsp_pop;

  logic          iter_last;
  logic          iter_first;
  logic          have_work;
  logic          issue_fire;
  logic          bypass;
  logic          slot_live;
  logic          cap_live;
  logic [CW-1:0] credits;

`ifdef DIV_TAG_EN
  logic [DIV_TW-1:0] cap_tag;
`else
  logic unused_req_tag;
  assign unused_req_tag = ^req_tag;
`endif

  always_comb begin
    req_in           = '0;
    req_in.op1       = req_op1;
    req_in.op2       = req_op2;
    req_in.unsigned_ = req_unsigned;
`ifdef DIV_TAG_EN
    req_in.tag       = req_tag;
`endif
  end

  assign iter_last  = (div_iter == 4'd15);
  assign iter_first = (div_iter == 4'd0);

  assign req_ready  = !req_full;
  assign req_fire   = req_valid && req_ready;
  assign have_work  = !req_empty || req_fire;
  assign issue_fire = iter_last && have_work && (credits != '0);
  // A request arriving on the issue edge into an empty queue goes straight to the
  // issue registers; this is what gives the 18-cycle best case.
  assign bypass     = issue_fire && req_empty;
  assign req_push   = req_fire && !bypass;
  assign req_pop    = issue_fire && !req_empty;
  assign issue_src  = req_empty ? req_in : req_head;

  div_sfifo #(
    .WIDTH ($bits(div_req_t)),
    .DEPTH (QDEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_push),
    .din   (req_in),
    .pop   (req_pop),
    .dout  (req_head),
    .full  (req_full),
    .empty (req_empty)
  );

  // Issue registers are only written on the div_iter==15 edge, so the divider
  // sees constant operands (including the signedness select) for a whole window.
  // cap_live/cap_tag take the outgoing window's state before it is replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_q           <= '0;
      issue_q.unsigned_ <= 1'b1;
      slot_live         <= 1'b0;
      cap_live          <= 1'b0;
`ifdef DIV_TAG_EN
      cap_tag           <= '0;
`endif
    end else if (iter_last) begin
      cap_live <= slot_live;
`ifdef DIV_TAG_EN
      cap_tag  <= issue_q.tag;
`endif
      if (issue_fire) begin
        issue_q   <= issue_src;
        slot_live <= 1'b1;
      end else begin
        issue_q           <= '0;
        issue_q.unsigned_ <= 1'b1;
        slot_live         <= 1'b0;
      end
    end
  end

  assign div_op1      = issue_q.op1;
  assign div_op2      = issue_q.op2;
  assign div_unsigned = issue_q.unsigned_;

  // The divider's result for the finished window is valid in the first cycle of
  // the next window.
  assign rsp_push = iter_first && cap_live;
  assign rsp_pop  = rsp_valid && rsp_ready;

  always_comb begin
    rsp_in      = '0;
    rsp_in.quot = div_quot;
    rsp_in.rem  = div_rem;
`ifdef DIV_TAG_EN
    rsp_in.tag  = cap_tag;
`endif
  end

  div_sfifo #(
    .WIDTH ($bits(div_rsp_t)),
    .DEPTH (RDEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_push),
    .din   (rsp_in),
    .pop   (rsp_pop),
    .dout  (rsp_head),
    .full  (rsp_full),
    .empty (rsp_empty)
  );

  assign rsp_valid = !rsp_empty;
  assign rsp_quot  = rsp_head.quot;
  assign rsp_rem   = rsp_head.rem;
`ifdef DIV_TAG_EN
  assign rsp_tag   = rsp_head.tag;
`else
  assign rsp_tag   = '0;
`endif

  // One credit per result slot: taken at issue, returned when a result leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= CREDIT_MAX;
    end else begin
      case ({issue_fire, rsp_pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  rsp_push_never_full: assert property (@(posedge clk) disable iff (!rst_n) rsp_push |-> !rsp_full);

endmodule

// File: tb/tb_div_issue_queue.sv
module tb_div_issue_queue;

  localparam int WL = 16;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid;
  logic            req_ready;
  logic [2*WL-1:0] req_op1;
  logic [WL-1:0]   req_op2;
  logic            req_unsigned;
  logic [TW-1:0]   req_tag;
  logic [2*WL-1:0] div_op1;
  logic [WL-1:0]   div_op2;
  logic            div_unsigned;
  logic [3:0]      div_iter = 4'd0;
  logic [WL-1:0]   div_quot;
  logic [WL-1:0]   div_rem;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [WL-1:0]   rsp_quot;
  logic [WL-1:0]   rsp_rem;
  logic [TW-1:0]   rsp_tag;

  int n_checks = 0;
  int n_fail   = 0;

  div_issue_queue #(.WL(WL), .QDEPTH(4), .RDEPTH(2), .TW(TW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .req_unsigned (req_unsigned),
    .req_tag      (req_tag),
    .div_op1      (div_op1),
    .div_op2      (div_op2),
    .div_unsigned (div_unsigned),
    .div_iter     (div_iter),
    .div_quot     (div_quot),
    .div_rem      (div_rem),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_quot     (rsp_quot),
    .rsp_rem      (rsp_rem),
    .rsp_tag      (rsp_tag)
  );

  always #5 clk = ~clk;

  // Free-running divider: iteration counter ignores the queue's reset.
  always @(posedge clk) div_iter <= div_iter + 4'd1;

  // Behavioural divider: result of the current window appears in its last cycle
  // and holds through the next window's first edge.
  int          sa, sb;
  logic [31:0] ua, ub;
  always @(negedge clk) begin
    if (div_iter == 4'd15) begin
      if (div_op2 == '0) begin
        div_quot = '1;
        div_rem  = div_op1[15:0];
      end else if (div_unsigned) begin
        ua = div_op1;
        ub = {16'h0, div_op2};
        div_quot = 16'(ua / ub);
        div_rem  = 16'(ua % ub);
      end else begin
        sa = div_op1;
        sb = {{16{div_op2[15]}}, div_op2};
        div_quot = 16'(sa / sb);
        div_rem  = 16'(sa % sb);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_tag(input int t);
`ifdef DIV_TAG_EN
    return 32'(t & 15);
`else
    return 32'(t & 0);
`endif
  endfunction

  task automatic wait_iter(input logic [3:0] v);
    do @(negedge clk); while (div_iter != v);
  endtask

  task automatic drive_req(input logic [31:0] op1, input logic [15:0] op2, input logic uns, input logic [3:0] tag);
    req_valid    = 1'b1;
    req_op1      = op1;
    req_op2      = op2;
    req_unsigned = uns;
    req_tag      = tag;
  endtask

  // Expects results with quotient base+k and tag k, k = 0..n-1, with rsp_ready held high.
  task automatic collect(input string nm, input int n, input logic [15:0] base, input int budget);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < budget) begin
      if (rsp_valid) begin
        check({nm, "_quot"}, 32'(rsp_quot), 32'(base) + 32'(got));
        check({nm, "_tag"}, 32'(rsp_tag), exp_tag(got));
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    check({nm, "_count"}, 32'(got), 32'(n));
  endtask

  typedef struct {
    logic [31:0] op1;
    logic [15:0] op2;
    logic        uns;
    logic [3:0]  tag;
    logic [15:0] q;
    logic [15:0] r;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int seen;
    int lat;
    int k;

    vecs[0] = '{op1: 32'd100,        op2: 16'd7,      uns: 1'b1, tag: 4'd3,  q: 16'h000E, r: 16'h0002};
    vecs[1] = '{op1: 32'hFFFFFF9C,   op2: 16'h0007,   uns: 1'b0, tag: 4'd5,  q: 16'hFFF2, r: 16'hFFFE};
    vecs[2] = '{op1: 32'h00010000,   op2: 16'h0002,   uns: 1'b1, tag: 4'd9,  q: 16'h8000, r: 16'h0000};
    vecs[3] = '{op1: 32'd1000,       op2: 16'hFFFD,   uns: 1'b0, tag: 4'd12, q: 16'hFEB3, r: 16'h0001};
    vecs[4] = '{op1: 32'd12345,      op2: 16'd100,    uns: 1'b1, tag: 4'd15, q: 16'h007B, r: 16'h002D};
    vecs[5] = '{op1: 32'hFFFFFFF9,   op2: 16'h0002,   uns: 1'b0, tag: 4'd1,  q: 16'hFFFD, r: 16'hFFFF};

    req_valid    = 1'b0;
    req_op1      = '0;
    req_op2      = '0;
    req_unsigned = 1'b0;
    req_tag      = '0;
    rsp_ready    = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_quot", 32'(rsp_quot), 32'd0);
    check("rst_rsp_rem", 32'(rsp_rem), 32'd0);
    check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    check("rst_div_op1", div_op1, 32'd0);
    check("rst_div_op2", 32'(div_op2), 32'd0);
    check("rst_div_unsigned", 32'(div_unsigned), 32'd1);
    check("rst_credits", 32'(dut.credits), 32'd2);
    rst_n = 1'b1;

    // Idle queue: bubbles only, never a result
    seen = 0;
    repeat (64) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("idle_rsp_valid_count", 32'(seen), 32'd0);
    check("idle_div_op1", div_op1, 32'd0);
    check("idle_div_op2", 32'(div_op2), 32'd0);
    check("idle_div_unsigned", 32'(div_unsigned), 32'd1);

    // Table: push on the issue edge, expect the result 18 cycles later as a single pulse
    for (int i = 0; i < 6; i++) begin
      wait_iter(4'd15);
      drive_req(vecs[i].op1, vecs[i].op2, vecs[i].uns, vecs[i].tag);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd18);
      check($sformatf("vec%0d_quot", i), 32'(rsp_quot), 32'(vecs[i].q));
      check($sformatf("vec%0d_rem", i), 32'(rsp_rem), 32'(vecs[i].r));
      check($sformatf("vec%0d_tag", i), 32'(rsp_tag), exp_tag(int'(vecs[i].tag)));
      @(negedge clk);
      check($sformatf("vec%0d_single_pulse", i), 32'(rsp_valid), 32'd0);
    end

    // Result backpressure: only RDEPTH requests issue, the rest wait in order
    rsp_ready = 1'b0;
    wait_iter(4'd3);
    for (int i = 0; i < 4; i++) begin
      drive_req(32'd100 + 32'(i), 16'd1, 1'b1, 4'(i));
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (70) @(negedge clk);
    check("bp_credits", 32'(dut.credits), 32'd0);
    check("bp_req_fifo_count", 32'(dut.u_req_fifo.cnt), 32'd2);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_head_quot", 32'(rsp_quot), 32'd100);
    check("bp_head_tag", 32'(rsp_tag), exp_tag(0));
    check("bp_req_ready", 32'(req_ready), 32'd1);
    rsp_ready = 1'b1;
    collect("bp_drain", 4, 16'd100, 300);

    // Request FIFO full: 5th push stalls until the first issue frees a slot
    wait_iter(4'd1);
    for (int i = 0; i < 4; i++) begin
      drive_req(32'd200 + 32'(i), 16'd1, 1'b1, 4'(i));
      @(negedge clk);
    end
    drive_req(32'd204, 16'd1, 1'b1, 4'd4);
    check("full_req_ready_5th", 32'(req_ready), 32'd0);
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("full_accept_iter", 32'(div_iter), 32'd0);
    check("full_accept_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    collect("full_drain", 5, 16'd200, 400);

    // Reset in mid-window discards the in-flight request
    wait_iter(4'd15);
    drive_req(32'd300, 16'd1, 1'b1, 4'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_slot_live", 32'(dut.slot_live), 32'd1);
    wait_iter(4'd7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_credits", 32'(dut.credits), 32'd2);
    check("mid_div_op1", div_op1, 32'd0);
    check("mid_div_unsigned", 32'(div_unsigned), 32'd1);
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("mid_no_result", 32'(seen), 32'd0);
    drive_req(32'd400, 16'd2, 1'b1, 4'd0);
    @(negedge clk);
    req_valid = 1'b0;
    collect("mid_after", 1, 16'd200, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
